fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch front end of the RV32I core. Sits directly upstream of the combinational instruction memory.
- Owns the program counter, drives the memory word address, and captures each returned instruction with its PC into a 2-entry fetch queue.
- Presents entries to decode through a valid/ready handshake.
- Handles control-flow redirects from execute, and raises a fault on misaligned or out-of-range fetch addresses.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- MEM_WORDS, 2048, instruction memory depth in 32-bit words. Legal fetch range is 0 .. MEM_WORDS*4-4.
- DEPTH, 2, fetch queue entries. Fixed at 2; other values are not supported.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_addr  output  32  byte address to instruction memory; equals fetch_pc.
- imem_instr  input  32  instruction read combinationally at imem_addr in the same cycle.
- redirect_valid  input  1  execute requests a PC change (branch taken, jal, jalr).
- redirect_pc  input  32  redirect target byte address.
- id_ready  input  1  decode accepts the head entry this cycle.
- if_valid  output  1  head entry valid.
- if_instr  output  32  head instruction; 32'h0000_0013 (NOP) when if_valid=0.
- if_pc  output  32  head PC; 0 when if_valid=0.
- fetch_fault  output  1  fetch halted on a bad address.
- fault_pc  output  32  offending address, held while fetch_fault=1.

Behaviour:
- Reset (asynchronous, any time, including mid-redirect or with a full queue):
  - fetch_pc=RESET_PC, count=0, state=RUN.
  - Outputs: if_valid=0, if_instr=NOP, if_pc=0, fetch_fault=0, fault_pc=0.
- imem_addr = fetch_pc at all times (combinational from the register).
- pop = if_valid & id_ready.
- push = state==RUN & !redirect_valid & in_range(fetch_pc) & (count<2 | pop).
- in_range(a): a < MEM_WORDS*4, unsigned compare.
- On push:
  - Enqueue {fetch_pc, imem_instr} at the tail.
  - fetch_pc <= fetch_pc+4, modulo 2^32. Wrap to 0 is legal arithmetic; the range check catches it first with default MEM_WORDS.
- When push is blocked by a full queue with no pop, fetch_pc holds.
- Simultaneous push and pop at count=2: count stays 2, head advances, new entry lands at the tail.
- Queue order is strict FIFO. The head is held stable while if_valid=1 and id_ready=0.
- Latency:
  - An instruction fetched in cycle t appears at the head no earlier than t+1.
  - First if_valid=1 is the cycle after the first clk edge following reset release.
- Redirect (redirect_valid=1 at edge t) has priority over push, pop and the fault check:
  - Queue flushed (count<=0); any pop that cycle is discarded. Decode ignores id_ready-qualified data on the flush edge.
  - If redirect_pc[1:0]!=0:
    - state<=FAULT, fetch_fault<=1, fault_pc<=redirect_pc.
    - fetch_pc<={redirect_pc[31:2],2'b00}.
  - Else:
    - fetch_pc<=redirect_pc, state<=RUN.
    - Clears any existing fault: fetch_fault<=0, fault_pc<=0.
  - Result: if_valid=0 at t+1; the target instruction is valid at the head at t+2 at the earliest.
- Range fault (state RUN, no redirect, !in_range(fetch_pc)):
  - state<=FAULT, fetch_fault<=1, fault_pc<=fetch_pc, no push.
  - Queued entries still drain normally.
- State FAULT:
  - No pushes; fetch_pc holds.
  - The only exit is a redirect with an aligned target, or reset.
- Redirect in the same cycle as a range fault: the redirect wins and the fault is not recorded.

Test Plan:
- Reset release, id_ready=1, memory[k]=k+1 -> if_pc 0,4,8,12 on consecutive cycles with if_instr 1,2,3,4; first if_valid=1 one cycle after the first post-reset edge.
- Backpressure: id_ready=0 for 4 cycles from reset -> count saturates at 2 (PCs 0,4), imem_addr holds 8, if_pc holds 0; release -> 0,4,8 delivered in order with no loss or duplication.
- Redirect to 0x40 while the queue is full and id_ready=1 -> if_valid=0 next cycle, then if_pc=0x40 with mem[16]; the flushed PCs 4 and 8 never reappear.
- Redirect to 0x42 -> fetch_fault=1, fault_pc=0x42, no further if_valid; then redirect to 0x80 -> fetch_fault=0, if_pc=0x80 delivered.
- MEM_WORDS=2048, redirect to 0x1FFC -> 0x1FFC delivered, then fetch_fault=1, fault_pc=0x2000.
- Assert reset for 1 cycle mid-stream with the queue full and a redirect pending -> all outputs at reset values immediately; fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: owns the PC, reads the combinational imem and
// buffers {pc, instr} pairs in a 2-entry FIFO toward decode.
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_WORDS = 2048,
    parameter int          DEPTH     = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_ready,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_fault,
    output logic [31:0] fault_pc
);
    localparam logic [31:0] NOP       = 32'h0000_0013;
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    localparam logic [1:0]  FULL      = 2'(DEPTH);

    typedef enum logic {RUN, FAULT} state_t;

    state_t      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] fault_pc_q, fault_pc_d;
    logic [1:0]  count_q, count_d;
    // Entry 0 is always the head; entry 1 shifts down on pop.
    logic [31:0] pc0_q, pc0_d, pc1_q, pc1_d;
    logic [31:0] in0_q, in0_d, in1_q, in1_d;

    logic in_range, pop, push;

    assign in_range = {1'b0, fetch_pc_q} < MEM_BYTES;
    assign pop      = if_valid & id_ready;
    assign push     = (state_q == RUN) & ~redirect_valid & in_range & ((count_q < FULL) | pop);

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_pc_d = fault_pc_q;
        count_d    = count_q;
        pc0_d      = pc0_q;
        pc1_d      = pc1_q;
        in0_d      = in0_q;
        in1_d      = in1_q;
        if (redirect_valid) begin
            count_d = 2'd0;
            if (redirect_pc[1:0] != 2'b00) begin
                state_d    = FAULT;
                fault_pc_d = redirect_pc;
                fetch_pc_d = {redirect_pc[31:2], 2'b00};
            end else begin
                state_d    = RUN;
                fault_pc_d = 32'd0;
                fetch_pc_d = redirect_pc;
            end
        end else begin
            if (state_q == RUN && !in_range) begin
                state_d    = FAULT;
                fault_pc_d = fetch_pc_q;
            end
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        pc0_d = fetch_pc_q;
                        in0_d = imem_instr;
                    end else begin
                        pc1_d = fetch_pc_q;
                        in1_d = imem_instr;
                    end
                    count_d = count_q + 2'd1;
                end
                2'b01: begin
                    pc0_d   = pc1_q;
                    in0_d   = in1_q;
                    count_d = count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        pc0_d = fetch_pc_q;
                        in0_d = imem_instr;
                    end else begin
                        pc0_d = pc1_q;
                        in0_d = in1_q;
                        pc1_d = fetch_pc_q;
                        in1_d = imem_instr;
                    end
                end
                default: ;
            endcase
            if (push) fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= RUN;
            fetch_pc_q <= RESET_PC;
            fault_pc_q <= 32'd0;
            count_q    <= 2'd0;
            pc0_q      <= 32'd0;
            pc1_q      <= 32'd0;
            in0_q      <= NOP;
            in1_q      <= NOP;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_pc_q <= fault_pc_d;
            count_q    <= count_d;
            pc0_q      <= pc0_d;
            pc1_q      <= pc1_d;
            in0_q      <= in0_d;
            in1_q      <= in1_d;
        end
    end

    assign imem_addr   = fetch_pc_q;
    assign if_valid    = count_q != 2'd0;
    assign if_instr    = if_valid ? in0_q : NOP;
    assign if_pc       = if_valid ? pc0_q : 32'd0;
    assign fetch_fault = state_q == FAULT;
    assign fault_pc    = fault_pc_q;
endmodule
